noc_packet_injector: RTL and testbench

//   Upstream traffic sequencer for noc_adder_top: issues a run of NUM_PACKETS transactions, each a
//   one-cycle START pulse followed by a one-cycle START2 pulse, then waits for DONE before the next.

---
 rtl/noc_packet_injector.sv | 140 ++++++++++++++
 tb/tb_noc_packet_injector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// Upstream traffic sequencer: on go, issues NUM_PACKETS start/start2 pulse pairs, each followed by
// a wait for done, recording per-packet start->done latency and aborting a run on done timeout.
module noc_packet_injector #(
  parameter int NUM_PACKETS    = 5,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             done,
  output logic             start,
  output logic             start2,
  output logic             busy,
  output logic             finished,
  output logic             timeout_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_max
);

  if (NUM_PACKETS < 1) begin : g_bad_num_packets
    $error("noc_packet_injector: NUM_PACKETS must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("noc_packet_injector: TIMEOUT_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("noc_packet_injector: GAP_CYCLES must be >= 0");
  end

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 2);

  localparam logic [CNT_W-1:0]  LAST_PKT   = CNT_W'(NUM_PACKETS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LIMIT  = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_S1,
    S_S2,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  lat;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start       <= 1'b0;
      start2      <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
      lat_last    <= '0;
      lat_max     <= '0;
      lat         <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      // NOTE: these non-blocking defaults make start/start2 single-cycle pulses; a later
      // assignment to the same register further down this block takes precedence.
      start  <= 1'b0;
      start2 <= 1'b0;

      // Latency runs from S1 entry until done, saturating instead of wrapping.
      if ((state == S_S1 || state == S_S2 || state == S_WAIT) && lat != '1)
        lat <= lat + 1'b1;

      case (state)
        S_IDLE, S_FIN: begin
          if (go) begin
            state       <= S_S1;
            start       <= 1'b1;
            busy        <= 1'b1;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
            pkt_count   <= '0;
            lat_last    <= '0;
            lat_max     <= '0;
            lat         <= CNT_W'(1);
          end
        end
        S_S1: begin
          state  <= S_S2;
          start2 <= 1'b1;
        end
        S_S2: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (done) begin
            pkt_count <= pkt_count + 1'b1;
            lat_last  <= lat;
            if (lat > lat_max) lat_max <= lat;
            if (pkt_count == LAST_PKT) begin
              state    <= S_FIN;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              state <= S_S1;
              start <= 1'b1;
              lat   <= CNT_W'(1);
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(1);
            end
          end else if (wait_cnt == WAIT_LIMIT) begin
            state       <= S_FIN;
            busy        <= 1'b0;
            finished    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LIMIT) begin
            state <= S_S1;
            start <= 1'b1;
            lat   <= CNT_W'(1);
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector: three instances (defaults, short timeout, zero gap) driven by a
// cycle schedule derived from the packet rules, with a packet-level model of count and latency stats.
module tb_noc_packet_injector;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        go          [3];
  logic        done        [3];
  logic        start       [3];
  logic        start2      [3];
  logic        busy        [3];
  logic        finished    [3];
  logic        timeout_err [3];
  logic [15:0] pkt_count   [3];
  logic [15:0] lat_last    [3];
  logic [15:0] lat_max     [3];

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt  [3];
  int exp_last [3];
  int exp_max  [3];
  int lats     [N];

  always #5 clk = ~clk;

  noc_packet_injector u0 (
    .clk(clk), .rst(rst), .go(go[0]), .done(done[0]),
    .start(start[0]), .start2(start2[0]), .busy(busy[0]), .finished(finished[0]),
    .timeout_err(timeout_err[0]), .pkt_count(pkt_count[0]),
    .lat_last(lat_last[0]), .lat_max(lat_max[0])
  );

  noc_packet_injector #(.TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .go(go[1]), .done(done[1]),
    .start(start[1]), .start2(start2[1]), .busy(busy[1]), .finished(finished[1]),
    .timeout_err(timeout_err[1]), .pkt_count(pkt_count[1]),
    .lat_last(lat_last[1]), .lat_max(lat_max[1])
  );

  noc_packet_injector #(.GAP_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .go(go[2]), .done(done[2]),
    .start(start[2]), .start2(start2[2]), .busy(busy[2]), .finished(finished[2]),
    .timeout_err(timeout_err[2]), .pkt_count(pkt_count[2]),
    .lat_last(lat_last[2]), .lat_max(lat_max[2])
  );

  function automatic int gap_of(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int d);
    check("rst_start", 32'(start[d]), 0);
    check("rst_start2", 32'(start2[d]), 0);
    check("rst_busy", 32'(busy[d]), 0);
    check("rst_finished", 32'(finished[d]), 0);
    check("rst_timeout", 32'(timeout_err[d]), 0);
    check("rst_pkt_count", 32'(pkt_count[d]), 0);
    check("rst_lat_last", 32'(lat_last[d]), 0);
    check("rst_lat_max", 32'(lat_max[d]), 0);
  endtask

  // Pulse go for one cycle; leaves the bench in the cycle where start must be high.
  task automatic start_run(input int d);
    go[d] = 1'b1;
    tick();
    go[d] = 1'b0;
    exp_cnt[d]  = 0;
    exp_last[d] = 0;
    exp_max[d]  = 0;
    check("run_clr_cnt", 32'(pkt_count[d]), 0);
    check("run_clr_last", 32'(lat_last[d]), 0);
    check("run_clr_max", 32'(lat_max[d]), 0);
    check("run_clr_timeout", 32'(timeout_err[d]), 0);
    check("run_clr_finished", 32'(finished[d]), 0);
  endtask

  // One packet with done returned at latency lat (>= 3); noise adds done in S2/GAP and go in WAIT.
  task automatic pkt(input int d, input int lat, input bit noise);
    check("s1_start", 32'(start[d]), 1);
    check("s1_start2", 32'(start2[d]), 0);
    check("s1_busy", 32'(busy[d]), 1);
    tick();
    check("s2_start", 32'(start[d]), 0);
    check("s2_start2", 32'(start2[d]), 1);
    if (noise) done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
    check("wait_start2", 32'(start2[d]), 0);
    for (int c = 3; c < lat; c++) begin
      if (noise && c == 3) go[d] = 1'b1;
      check("wait_cnt_hold", 32'(pkt_count[d]), 32'(exp_cnt[d]));
      tick();
      go[d] = 1'b0;
    end
    done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
    exp_cnt[d]++;
    exp_last[d] = lat;
    if (lat > exp_max[d]) exp_max[d] = lat;
    check("pkt_count", 32'(pkt_count[d]), 32'(exp_cnt[d]));
    check("lat_last", 32'(lat_last[d]), 32'(exp_last[d]));
    check("lat_max", 32'(lat_max[d]), 32'(exp_max[d]));
    if (exp_cnt[d] < N) begin
      for (int g = 0; g < gap_of(d); g++) begin
        check("gap_start", 32'(start[d]), 0);
        check("gap_busy", 32'(busy[d]), 1);
        if (noise) done[d] = 1'b1;
        tick();
        done[d] = 1'b0;
      end
    end
  endtask

  task automatic check_final(input int d);
    check("fin_finished", 32'(finished[d]), 1);
    check("fin_busy", 32'(busy[d]), 0);
    check("fin_start", 32'(start[d]), 0);
    check("fin_timeout", 32'(timeout_err[d]), 0);
    check("fin_pkt_count", 32'(pkt_count[d]), N);
    check("fin_lat_last", 32'(lat_last[d]), 32'(exp_last[d]));
    check("fin_lat_max", 32'(lat_max[d]), 32'(exp_max[d]));
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      go[d]   = 1'b0;
      done[d] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) check_zero(d);

    // Fixed latency 6 (done four cycles after start2) on every packet.
    start_run(0);
    for (int i = 0; i < N; i++) pkt(0, 6, 1'b0);
    check_final(0);
    check("t1_lat_last", 32'(lat_last[0]), 6);
    check("t1_lat_max", 32'(lat_max[0]), 6);

    // Mixed latencies, rerun from FIN.
    lats = '{3, 9, 5, 4, 3};
    start_run(0);
    for (int i = 0; i < N; i++) pkt(0, lats[i], 1'b0);
    check_final(0);
    check("t2_lat_last", 32'(lat_last[0]), 3);
    check("t2_lat_max", 32'(lat_max[0]), 9);

    // Random latencies with stray done/go pulses that must be ignored.
    start_run(0);
    for (int i = 0; i < N; i++) pkt(0, int'($urandom_range(3, 12)), 1'b1);
    check_final(0);

    // Reset in the WAIT of packet 3, then a fresh run.
    start_run(0);
    pkt(0, int'($urandom_range(3, 8)), 1'b0);
    pkt(0, int'($urandom_range(3, 8)), 1'b0);
    check("t5_start", 32'(start[0]), 1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero(0);
    tick();
    check("t5_idle_start", 32'(start[0]), 0);
    check("t5_idle_busy", 32'(busy[0]), 0);
    start_run(0);
    for (int i = 0; i < N; i++) pkt(0, int'($urandom_range(3, 8)), 1'b0);
    check_final(0);

    // Short timeout: done on the last allowed WAIT cycle counts, then packet 2 times out.
    start_run(1);
    pkt(1, 10, 1'b0);
    check("t3_start", 32'(start[1]), 1);
    tick();
    check("t3_start2", 32'(start2[1]), 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("t3_no_timeout", 32'(timeout_err[1]), 0);
      check("t3_busy", 32'(busy[1]), 1);
      tick();
    end
    check("t3_timeout", 32'(timeout_err[1]), 1);
    check("t3_finished", 32'(finished[1]), 1);
    check("t3_busy_lo", 32'(busy[1]), 0);
    check("t3_pkt_count", 32'(pkt_count[1]), 1);
    check("t3_lat_last", 32'(lat_last[1]), 10);
    check("t3_lat_max", 32'(lat_max[1]), 10);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_no_start", 32'(start[1]), 0);
      check("t3_sticky", 32'(timeout_err[1]), 1);
    end
    start_run(1);
    for (int i = 0; i < N; i++) pkt(1, int'($urandom_range(3, 10)), 1'b0);
    check_final(1);

    // Zero gap: back-to-back packets, two identical runs.
    for (int i = 0; i < N; i++) lats[i] = int'($urandom_range(3, 9));
    start_run(2);
    for (int i = 0; i < N; i++) pkt(2, lats[i], 1'b1);
    check_final(2);
    start_run(2);
    for (int i = 0; i < N; i++) pkt(2, lats[i], 1'b0);
    check_final(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
